// File: rtl/l2_adaptor_pkg.sv
// Shared types and derived sizes for the L2 line-to-burst adaptor.
// The module parameters default to the DEF_* values so BEATS/OFS_W stay consistent.
package l2_adaptor_pkg;

    localparam int DEF_LINE_W = 256;
    localparam int DEF_BEAT_W = 64;
    localparam int DEF_ADDR_W = 32;

    localparam int BEATS = DEF_LINE_W / DEF_BEAT_W;
    localparam int OFS_W = $clog2(DEF_LINE_W / 8);
    localparam int CNT_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_e;

endpackage

// File: rtl/l2_line_adaptor.sv
// Converts single-shot 256-bit L2 line requests into 4-beat 64-bit memory bursts
// and returns a one-cycle line-level response.
module l2_line_adaptor
    import l2_adaptor_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int BEAT_W = DEF_BEAT_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [ADDR_W-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BEAT_W-1:0] burst_i,
    output logic [BEAT_W-1:0] burst_o,
    output logic [ADDR_W-1:0] address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    // Handshake: read_o/write_o stay high for the whole burst; every cycle with
    // resp_i=1 transfers exactly one beat, cycles with resp_i=0 change nothing.

    state_e            state_q;
    logic [CNT_W-1:0]  beat_q;
    logic [CNT_W-1:0]  beat_d;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wbuf_q;
    logic [LINE_W-1:0] line_q;
    logic              read_q;
    logic              write_q;
    logic              resp_q;
    logic              last_beat;

    assign beat_d    = beat_q + 1'b1;
    assign last_beat = (beat_q == CNT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            line_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (read_i || write_i) begin
                        addr_q <= {address_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                        beat_q <= '0;
                    end
                    // A simultaneous read/write is illegal; the write-back takes priority.
                    if (write_i) begin
                        wbuf_q  <= line_i;
                        write_q <= 1'b1;
                        state_q <= WR_BURST;
                    end else if (read_i) begin
                        read_q  <= 1'b1;
                        state_q <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (beat_q == CNT_W'(b)) begin
                                line_q[b*BEAT_W +: BEAT_W] <= burst_i;
                            end
                        end
                        beat_q <= beat_d;
                        if (last_beat) begin
                            read_q  <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                WR_BURST: begin
                    if (resp_i) begin
                        beat_q <= beat_d;
                        if (last_beat) begin
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        burst_o = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (write_q && beat_q == CNT_W'(b)) begin
                burst_o = wbuf_q[b*BEAT_W +: BEAT_W];
            end
        end
    end

    assign line_o    = line_q;
    assign address_o = addr_q;
    assign read_o    = read_q;
    assign write_o   = write_q;
    assign resp_o    = resp_q;

    a_no_dual_req: assert property (@(posedge clk) disable iff (rst)
        (state_q == IDLE) |-> !(read_i && write_i))
        else $error("l2_line_adaptor: read_i and write_i asserted together");

endmodule

// File: tb/tb_l2_line_adaptor.sv
// Directed plus randomized bench for l2_line_adaptor with a line-level reference model.
module tb_l2_line_adaptor;
    import l2_adaptor_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic [31:0]  address_i;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic [31:0]  address_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    l2_line_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .line_i    (line_i),
        .line_o    (line_o),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_total++;
        n_fail++;
        $error("FAIL %s: burst did not complete within cycle budget", tag);
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // mode: 0 fixed beats/no stall, 1 stall pattern 1,0,0,1,1,0,1, 2 random stalls, 3 no stall
    task automatic run_read(input logic [31:0] addr, input int mode);
        logic [63:0]  beats[4];
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        logic [6:0]   pat;
        logic         r;
        int           n;
        int           cyc;
        pat = 7'b1011001;
        for (int i = 0; i < 4; i++) begin
            beats[i] = (mode == 0) ? {16{4'(i + 1)}} : {$urandom, $urandom};
        end
        exp_line = {beats[3], beats[2], beats[1], beats[0]};
        exp_addr = {addr[31:5], 5'b0};
        read_i = 1'b1;
        address_i = addr;
        step();
        n = 0;
        cyc = 0;
        while (n < 4 && cyc < 64) begin
            check("rd_read_o", read_o, 1);
            check("rd_write_o", write_o, 0);
            check("rd_resp_o_early", resp_o, 0);
            check("rd_address_o", address_o, exp_addr);
            case (mode)
                1:       r = (cyc < 7) ? pat[cyc] : 1'b1;
                2:       r = 1'($urandom_range(0, 1));
                default: r = 1'b1;
            endcase
            resp_i = r;
            burst_i = r ? beats[n] : {$urandom, $urandom};
            address_i = $urandom;
            step();
            if (r) n++;
            cyc++;
        end
        if (n < 4) timeout_fail("rd_timeout");
        resp_i = 1'b0;
        burst_i = '0;
        check("rd_resp_o", resp_o, 1);
        check("rd_read_o_off", read_o, 0);
        check("rd_write_o_off", write_o, 0);
        check("rd_line_o", line_o, exp_line);
        read_i = 1'b0;
        step();
        check("rd_resp_o_single", resp_o, 0);
        check("rd_read_o_idle", read_o, 0);
        check("rd_line_o_hold", line_o, exp_line);
    endtask

    // mode: 0 no stall, 2 random stalls; address_i/line_i churn throughout the burst
    task automatic run_write(input logic [31:0] addr, input logic [255:0] line, input int mode);
        logic [63:0] exp_q[$];
        logic [31:0] exp_addr;
        logic        r;
        int          cyc;
        for (int i = 0; i < 4; i++) exp_q.push_back(line[i*64 +: 64]);
        exp_addr = {addr[31:5], 5'b0};
        write_i = 1'b1;
        address_i = addr;
        line_i = line;
        step();
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 64) begin
            check("wr_write_o", write_o, 1);
            check("wr_read_o", read_o, 0);
            check("wr_resp_o_early", resp_o, 0);
            check("wr_address_o", address_o, exp_addr);
            check("wr_burst_o", burst_o, exp_q[0]);
            r = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            resp_i = r;
            address_i = $urandom;
            line_i = rand_line();
            step();
            if (r) void'(exp_q.pop_front());
            cyc++;
        end
        if (exp_q.size() > 0) timeout_fail("wr_timeout");
        resp_i = 1'b0;
        check("wr_resp_o", resp_o, 1);
        check("wr_write_o_off", write_o, 0);
        check("wr_read_o_off", read_o, 0);
        write_i = 1'b0;
        step();
        check("wr_resp_o_single", resp_o, 0);
        check("wr_write_o_idle", write_o, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_resp_o"}, resp_o, 0);
        check({tag, "_read_o"}, read_o, 0);
        check({tag, "_write_o"}, write_o, 0);
        check({tag, "_address_o"}, address_o, 0);
        check({tag, "_burst_o"}, burst_o, 0);
        check({tag, "_line_o"}, line_o, 0);
        check({tag, "_state"}, dut.state_q, IDLE);
    endtask

    initial begin
        rst = 1'b1;
        line_i = '0;
        address_i = '0;
        read_i = 1'b0;
        write_i = 1'b0;
        burst_i = '0;
        resp_i = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst = 1'b0;
        step();

        run_read(32'h0000_1234, 0);

        run_write(32'h0000_8000,
                  {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 0);
        run_read($urandom, 3);

        run_read($urandom, 1);

        read_i = 1'b1;
        address_i = 32'h0000_5A47;
        step();
        for (int i = 0; i < 2; i++) begin
            resp_i = 1'b1;
            burst_i = {$urandom, $urandom};
            step();
        end
        resp_i = 1'b0;
        read_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_all_zero("midrst");
        step();
        check("midrst_no_resp", resp_o, 0);
        check("midrst_no_read", read_o, 0);
        run_read($urandom, 3);

        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) run_write($urandom, rand_line(), 2);
            else run_read($urandom, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/l2_line_adaptor.md
Name: l2_line_adaptor

Overview:
- Sits directly downstream of the L2 cache controller/datapath. Converts its single-shot 256-bit line requests (pmem_read / pmem_write / pmem_resp) into a 4-beat, 64-bit burst transaction on the physical-memory port.
- Latches the line address and write data on acceptance and serialises or deserialises beats with a beat counter.
- Returns a one-cycle line-level response to the L2.

Parameters:
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, memory burst beat width in bits.
- ADDR_W, 32, byte address width.
- Derived localparam BEATS = LINE_W/BEAT_W (4). Derived localparam OFS_W = log2(LINE_W/8) (5).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- line_i  in  LINE_W  write-back line from L2.
- line_o  out  LINE_W  refill line to L2.
- address_i  in  ADDR_W  line address from L2.
- read_i  in  1  L2 refill request (pmem_read).
- write_i  in  1  L2 write-back request (pmem_write).
- resp_o  out  1  line transfer complete (pmem_resp).
- burst_i  in  BEAT_W  read beat from memory.
- burst_o  out  BEAT_W  write beat to memory.
- address_o  out  ADDR_W  line-aligned burst address.
- read_o  out  1  memory burst read request.
- write_o  out  1  memory burst write request.
- resp_i  in  1  memory beat accepted/valid.

Behaviour:
- FSM states: IDLE, RD_BURST, WR_BURST, DONE.
- Reset: state=IDLE, beat count=0, resp_o=0, read_o=0, write_o=0, address_o=0, burst_o=0, line_o=0.
- Reset mid-burst aborts immediately: no resp_o is issued, and the partial line_o contents are discarded (line_o=0).
- IDLE, accepting a request:
  - On read_i=1 or write_i=1, latch {address_i[ADDR_W-1:OFS_W], OFS_W'b0} into the address register.
  - On write_i, also latch line_i into the shift buffer.
  - Clear the beat count.
  - Go to RD_BURST (read_i) or WR_BURST (write_i).
  - If both are asserted, write wins. This is a protocol violation and must be flagged by an assertion.
- RD_BURST:
  - read_o=1 and address_o=latched address throughout.
  - Each cycle with resp_i=1 stores burst_i into line_o[BEAT_W*k +: BEAT_W], k = beat count, then increments k.
  - resp_i may be non-consecutive; cycles with resp_i=0 change nothing.
  - On the beat with k=BEATS-1, go to DONE. read_o deasserts starting the next cycle.
- WR_BURST:
  - write_o=1, address_o=latched address.
  - burst_o = buffer[BEAT_W*k +: BEAT_W], combinational from the count.
  - Each resp_i=1 advances k. On the last beat, go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle. read_o=0, write_o=0.
  - Next state is IDLE unconditionally.
  - The L2 drops its request in the cycle after resp_o, so requests are only ever sampled in IDLE and a stale request cannot retrigger.
- line_o holds the last completed refill until the next read's first beat. It is only guaranteed valid while resp_o=1.
- Latency (no memory stalls): request seen at cycle T; burst request T+1..T+4 with resp_i each cycle; resp_o at T+5.
- Back-to-back write-back then refill: the earliest read_i acceptance is the cycle after DONE.
- Beat count: 2-bit counter, wraps to 0 after the final beat; it is never observed at BEATS.
- address_i, line_i and read_i/write_i are ignored outside IDLE. Changes mid-burst must not affect address_o or burst_o.

Decomposition:
- Shared package l2_adaptor_pkg holds:
  - the state enum typedef (IDLE, RD_BURST, WR_BURST, DONE);
  - the localparams BEATS and OFS_W.
- No sub-module. The beat counter and the shift/capture buffer are inline.

Test Plan:
- Read, no stalls: read_i=1, address_i=0x0000_1234; memory returns beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on 4 consecutive resp_i. Required: address_o=0x0000_1220; read_o high 4 cycles; resp_o one cycle at T+5; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Write, no stalls: write_i=1, line_i = {0xDDDD.., 0xCCCC.., 0xBBBB.., 0xAAAA..}. Required: burst_o sequence AAAA, BBBB, CCCC, DDDD; write_o high 4 cycles; single resp_o.
- Stalled read: resp_i pattern 1,0,0,1,1,0,1. Required: line_o assembled correctly; resp_o exactly one cycle, after the 4th accepted beat.
- Write-back then refill: write_i serviced; L2 raises read_i on the cycle after resp_o. Required: read accepted, new address_o presented, no overlap of write_o and read_o.
- Reset mid-read after 2 beats: rst=1 for one cycle. Required: next cycle all outputs 0, state IDLE, no resp_o. A subsequent read completes normally.
- Input churn: change address_i and line_i during WR_BURST. Required: address_o and burst_o unaffected.
